// File: rtl/arm_fetch_pkg.sv
// Shared widths, reset vector and FSM state encoding for the instruction-fetch front end.
package arm_fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush beats push, full push is legal with a pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner and instruction-memory request sequencer with branch redirect and prefetch buffering.
module fetch_sequencer
  import arm_fetch_pkg::*;
#(
  parameter int                ADDR_W     = arm_fetch_pkg::ADDR_W,
  parameter int                DATA_W     = arm_fetch_pkg::DATA_W,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(arm_fetch_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output fetch_state_e      fsm_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;

  // Handshake: a transfer happens on any rising edge where mem_req & mem_ready;
  // once raised, mem_req and mem_addr hold until that edge.
  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_addr;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              push;
  logic              pop;
  logic              abandon;

  assign fsm_state = state;
  assign pop       = if_valid & ~freeze & ~branch_taken;

  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = fetch_pc;
    state_next = state;
    push       = 1'b0;
    abandon    = 1'b0;
    case (state)
      FETCH: begin
        mem_req = (count < CW'(FIFO_DEPTH)) | pop;
        push    = mem_req & mem_ready & ~branch_taken;
        // A redirect with a request still outstanding must wait out that request.
        abandon = branch_taken & mem_req & ~mem_ready;
        if (abandon) state_next = DISCARD;
      end
      DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (mem_ready) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      push    = 1'b0;
      abandon = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_next;
      if (branch_taken) begin
        fetch_pc <= {branch_addr[ADDR_W-1:2], 2'b00};
      end else if (state == FETCH && mem_req && mem_ready) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (abandon) req_addr <= mem_addr;
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .din   ({fetch_pc + ADDR_W'(4), mem_rdata}),
    .dout  (head),
    .count (count)
  );

  assign if_valid = ~rst & (count != '0);
  assign if_pc    = if_valid ? head[EW-1:DATA_W] : '0;
  assign if_instr = if_valid ? head[DATA_W-1:0]  : '0;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench: memory and consumer models drive the sequencer; a scoreboard checks the fetched stream.
module tb_fetch_sequencer;
  import arm_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  fetch_state_e fsm_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  fetch_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // reference model state
  logic [31:0] fetch_next;
  bit          abandoned_v;
  logic [31:0] abandoned_addr;
  bit          mem_busy;
  int          mem_lat;
  int          mem_wcnt;
  bit          prev_pending;
  logic [31:0] prev_addr;

  // phase table: cycles, max wait states, freeze %, branch %, reset %
  localparam int NPH = 6;
  int ph_cyc [NPH] = '{60, 60, 200, 400, 400, 400};
  int ph_wait[NPH] = '{0, 2, 0, 3, 1, 2};
  int ph_frz [NPH] = '{0, 0, 50, 30, 20, 40};
  int ph_br  [NPH] = '{0, 0, 0, 10, 30, 15};
  int ph_rst [NPH] = '{0, 0, 0, 0, 0, 3};

  function automatic logic [31:0] pick_target();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return $urandom & 32'h0000_0FFF;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    fetch_next   = RESET_PC;
    abandoned_v  = 1'b0;
    mem_busy     = 1'b0;
    prev_pending = 1'b0;
  endtask

  // driver: memory and consumer stimulus plus request-side model
  initial begin
    bit exp_req;
    bit pop_exp;
    bit hs;
    logic [31:0] cur_next;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    model_reset();
    for (int ph = 0; ph < NPH; ph++) begin
      for (int c = 0; c < ph_cyc[ph]; c++) begin
        @(negedge clk);
        if (ph == 0 && c < 2) rst = 1'b1;
        else rst = ($urandom_range(0, 99) < ph_rst[ph]);
        freeze       = ($urandom_range(0, 99) < ph_frz[ph]);
        branch_taken = !rst && ($urandom_range(0, 99) < ph_br[ph]);
        branch_addr  = pick_target();
        #1;
        if (mem_req) begin
          if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_wcnt = 0;
            mem_lat  = $urandom_range(0, ph_wait[ph]);
          end
          mem_ready = (mem_wcnt == mem_lat);
          mem_rdata = mem_ready ? rom(mem_addr) : 32'h0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'h0;
        end
        pop_exp = (exp_q.size() != 0) && !freeze && !branch_taken;
        exp_req = !rst && (abandoned_v || exp_q.size() < DEPTH || pop_exp);
        chk(mem_req == exp_req, "mem_req", 64'(mem_req), 64'(exp_req));
        if (mem_req && !abandoned_v)
          chk(mem_addr == fetch_next, "mem_addr", 64'(mem_addr), 64'(fetch_next));
        if (prev_pending && !rst)
          chk(mem_req && mem_addr == prev_addr, "req_hold", {31'b0, mem_req, mem_addr}, {32'h1, prev_addr});
        #2;
        if (rst) begin
          model_reset();
        end else begin
          hs       = mem_req && mem_ready;
          cur_next = fetch_next;
          if (mem_req) begin
            if (mem_ready) mem_busy = 1'b0;
            else mem_wcnt++;
          end
          if (hs) begin
            if (abandoned_v) begin
              chk(mem_addr == abandoned_addr, "discard_addr", 64'(mem_addr), 64'(abandoned_addr));
              abandoned_v = 1'b0;
            end else begin
              if (!branch_taken) exp_q.push_back({cur_next + 32'd4, rom(cur_next)});
              fetch_next = cur_next + 32'd4;
            end
          end
          if (branch_taken) begin
            exp_q.delete();
            if (mem_req && !mem_ready && !abandoned_v) begin
              abandoned_v    = 1'b1;
              abandoned_addr = cur_next;
            end
            fetch_next = branch_addr & 32'hFFFF_FFFC;
          end
          prev_pending = mem_req && !mem_ready;
          prev_addr    = mem_addr;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // monitor: consumer-side checks against the expected queue
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk(!if_valid && if_pc == 0 && if_instr == 0, "rst_outputs",
            {31'b0, if_valid, if_pc ^ if_instr}, 64'h0);
      end else begin
        chk(if_valid == (exp_q.size() != 0), "if_valid", 64'(if_valid), 64'(exp_q.size() != 0));
        if (if_valid && exp_q.size() != 0 && !freeze && !branch_taken) begin
          exp = exp_q.pop_front();
          chk({if_pc, if_instr} == exp, "head", {if_pc, if_instr}, exp);
        end else if (!if_valid) begin
          chk(if_pc == 0 && if_instr == 0, "empty_zero", {if_pc, if_instr}, 64'h0);
        end
      end
    end
  end
endmodule
